ttl_event_fifo: RTL and testbench

Timestamped event queue for the TTLx8 output path: buffers (timestamp, pattern) pairs written by the sequencer and drives the registered TTL output word when the global time counter reaches each entry's timestamp. It generalises the team's addressed register buffer into a self-managing circular FIFO with pointers, level tracking, flow control, late-event detection and sticky error flags. It sits between the command decoder (write side) and the TTL pin drivers (output side).

---
 rtl/ttl_event_fifo_if.sv | 13 +
 rtl/ttl_event_fifo.sv | 77 +++++++
 tb/tb_ttl_event_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ttl_event_fifo_if.sv
// Write channel from the command decoder into the TTL event queue.
interface ttl_event_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TIME_WIDTH = 64
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [TIME_WIDTH-1:0] wr_time;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output wr_valid, wr_time, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_time, wr_data, output wr_ready);
endinterface

// File: rtl/ttl_event_fifo.sv
// Timestamped circular event queue driving the registered TTL output word
// when time_now reaches each head entry's timestamp.
module ttl_event_fifo #(
  parameter int DEPTH             = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_WIDTH        = 8,
  parameter int TIME_WIDTH        = 64,
  parameter int ALMOST_FULL_LEVEL = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TIME_WIDTH-1:0] time_now,
  ttl_event_fifo_if.slave       wr,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] ttl_out,
  output logic                  fire,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  late
);
  localparam int EW = TIME_WIDTH + DATA_WIDTH;

  logic [EW-1:0]         mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
  logic [TIME_WIDTH-1:0] head_time;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  do_wr, wr_drop, do_issue, is_late;

  // Acceptance looks only at the registered full, so a same-cycle issue
  // never makes room for a write.
  assign wr.wr_ready = !full;
  assign do_wr       = wr.wr_valid && !full;
  assign wr_drop     = wr.wr_valid && full;

  assign {head_time, head_data} = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign do_issue = !empty && (head_time <= time_now);
  assign is_late  = do_issue && (head_time < time_now);

  assign wr_ptr_n = wr_ptr + (ADDR_WIDTH+1)'(do_wr);
  assign rd_ptr_n = rd_ptr + (ADDR_WIDTH+1)'(do_issue);
  assign level_n  = wr_ptr_n - rd_ptr_n;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr.wr_time, wr.wr_data};
  end

  // Status is registered from next-state pointers so it moves on the same
  // edge as the pointer change that causes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      ttl_out     <= '0;
      fire        <= 1'b0;
      overflow    <= 1'b0;
      late        <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      level       <= level_n;
      empty       <= (level_n == '0);
      full        <= (level_n == (ADDR_WIDTH+1)'(DEPTH));
      almost_full <= (level_n >= (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL));
      fire        <= do_issue;
      if (do_issue) ttl_out <= head_data;
      overflow    <= wr_drop | (overflow & !clear_flags);
      late        <= is_late | (late & !clear_flags);
    end
  end
endmodule

// File: tb/tb_ttl_event_fifo.sv
// Scoreboard bench for ttl_event_fifo: accepted writes queue expected patterns,
// each fire pops and compares ttl_out.
module tb_ttl_event_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] time_now;
  logic        clear_flags;
  logic [7:0]  ttl_out;
  logic        fire, empty, full, almost_full, overflow, late;
  logic [10:0] level;

  ttl_event_fifo_if #(.DATA_WIDTH(8), .TIME_WIDTH(64)) wif ();

  ttl_event_fifo dut (
    .clk(clk), .rst(rst), .time_now(time_now), .wr(wif), .clear_flags(clear_flags),
    .ttl_out(ttl_out), .fire(fire), .empty(empty), .full(full),
    .almost_full(almost_full), .level(level), .overflow(overflow), .late(late)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_pass = 0, fire_cnt = 0;
  logic [10:0] max_level = '0;
  logic [7:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_evt(input logic [63:0] t, input logic [7:0] d);
    wif.wr_valid = 1'b1; wif.wr_time = t; wif.wr_data = d;
    if (wif.wr_ready) sb.push_back(d);
    tick();
    wif.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (level > max_level) max_level = level;
      if (fire) begin
        fire_cnt++;
        if (sb.size() == 0) chk("spurious_fire", {56'd0, ttl_out}, 64'hDEAD);
        else chk("ttl_order", {56'd0, ttl_out}, {56'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    int f0;
    rst = 1'b1; time_now = '0; clear_flags = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_time = '0; wif.wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_af", almost_full, 0);
    chk("rst_level", level, 0); chk("rst_ttl", ttl_out, 0); chk("rst_fire", fire, 0);
    chk("rst_ovf", overflow, 0); chk("rst_late", late, 0); chk("rst_ready", wif.wr_ready, 1);

    // two on-time events
    wr_evt(64'd10, 8'h55);
    wr_evt(64'd20, 8'hAA);
    for (int t = 0; t < 25; t++) begin
      time_now = 64'(t);
      tick();
      if (t == 9)  chk("t1_before", ttl_out, 8'h00);
      if (t == 10) begin chk("t1_ttl55", ttl_out, 8'h55); chk("t1_fire", fire, 1); end
      if (t == 11) chk("t1_fire_pulse", fire, 0);
      if (t == 19) chk("t1_hold", ttl_out, 8'h55);
      if (t == 20) chk("t1_ttlAA", ttl_out, 8'hAA);
    end
    chk("t1_empty", empty, 1); chk("t1_late", late, 0);

    // late event and flag clear
    time_now = 64'd8;
    wr_evt(64'd5, 8'h0F);
    tick();
    chk("t2_ttl", ttl_out, 8'h0F); chk("t2_late", late, 1); chk("t2_fire", fire, 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("t2_clear", late, 0);

    // fill to full with far-future timestamps
    for (int i = 0; i < 1024; i++) begin
      wr_evt(64'h1_0000_0000 + 64'(i), 8'(i));
      if (i == 998) chk("t3_af_999", almost_full, 0);
      if (i == 999) chk("t3_af_1000", almost_full, 1);
    end
    chk("t3_full", full, 1); chk("t3_ready", wif.wr_ready, 0); chk("t3_level", level, 1024);
    wr_evt(64'd0, 8'h77);
    chk("t3_ovf", overflow, 1); chk("t3_level_hold", level, 1024);
    wif.wr_valid = 1'b1; clear_flags = 1'b1; tick();
    wif.wr_valid = 1'b0; clear_flags = 1'b0;
    chk("t3_set_wins", overflow, 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("t3_ovf_clear", overflow, 0);
    do_reset();
    chk("t3_flush_level", level, 0); chk("t3_flush_empty", empty, 1);

    // equal timestamps issue on successive cycles
    time_now = 64'd40;
    wr_evt(64'd50, 8'd1); wr_evt(64'd50, 8'd2); wr_evt(64'd50, 8'd3);
    f0 = fire_cnt;
    for (int t = 41; t < 56; t++) begin
      time_now = 64'(t);
      tick();
      if (t == 50) begin chk("t4_first", ttl_out, 1); chk("t4_first_late", late, 0); end
      if (t == 51) begin chk("t4_second", ttl_out, 2); chk("t4_second_late", late, 1); end
      if (t == 52) chk("t4_third", ttl_out, 3);
    end
    chk("t4_fires", 64'(fire_cnt - f0), 3); chk("t4_late", late, 1);

    // streaming with concurrent issue, pointers wrap
    do_reset();
    max_level = '0;
    f0 = fire_cnt;
    for (int i = 0; i < 3000; i++) begin
      time_now = 64'd100 + 64'(i);
      wr_evt(64'd102 + 64'(i), 8'(i * 7));
    end
    for (int i = 0; i < 10; i++) begin
      time_now = 64'd3100 + 64'(i);
      tick();
    end
    chk("t5_fires", 64'(fire_cnt - f0), 3000); chk("t5_late", late, 0);
    chk("t5_empty", empty, 1); chk("t5_sb_drained", 64'(sb.size()), 0);
    chk("t5_max_level", {63'd0, max_level <= 11'd1024}, 1);

    // reset with pending entries
    time_now = 64'd5000;
    wr_evt(64'd5000, 8'hFF);
    for (int i = 0; i < 5; i++) wr_evt(64'd5001 + 64'(i), 8'(i + 1));
    chk("t6_ttl_ff", ttl_out, 8'hFF); chk("t6_level5", level, 5);
    do_reset();
    chk("t6_ttl0", ttl_out, 0); chk("t6_level0", level, 0); chk("t6_empty", empty, 1);
    f0 = fire_cnt;
    for (int i = 0; i < 20; i++) begin
      time_now = 64'd5001 + 64'(i);
      tick();
    end
    chk("t6_no_fire", 64'(fire_cnt - f0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
